// File: rtl/risk_tile_engine.sv
// Tile load/store engine: moves SZ x SZ element tiles between a private scratch
// memory and a tile register file, LANES elements per beat, with strided addressing.
module risk_tile_engine #(
  parameter int SZ    = 3,
  parameter int BITS  = 32,
  parameter int NREG  = 32,
  parameter int LANES = 4,
  parameter int AW    = 15,
  parameter int SW    = 14,
  localparam int RW   = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_func,
  input  logic [RW-1:0]          cmd_reg,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [SW-1:0]          cmd_stride_x,
  input  logic [SW-1:0]          cmd_stride_y,
  output logic                   done,
  input  logic                   mem_we,
  input  logic [AW-1:0]          mem_waddr,
  input  logic [BITS-1:0]        mem_wdata,
  input  logic [AW-1:0]          mem_raddr,
  output logic [BITS-1:0]        mem_rdata,
  input  logic [RW-1:0]          view_reg,
  output logic [SZ*SZ*BITS-1:0]  reg_view
);

  localparam int NEL   = SZ * SZ;
  localparam int NB    = (NEL + LANES - 1) / LANES;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB, S_CLR} state_e;

  state_e          state_q, state_d;
  logic            is_load_q, is_load_d;
  logic [RW-1:0]   reg_q, reg_d;
  logic [AW-1:0]   base_q, base_d;
  logic [SW-1:0]   sx_q, sx_d;
  logic [SW-1:0]   sy_q, sy_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            wb_valid_q, wb_valid_d;
  logic [BW-1:0]   wb_beat_q, wb_beat_d;
  logic            done_q, done_d;

  logic [BITS-1:0] rf_q [NREG][NEL];
  logic [BITS-1:0] rf_d [NREG][NEL];

  logic [BITS-1:0] mem [DEPTH];
  logic [BITS-1:0] rd_data_q [LANES];
  logic [BITS-1:0] mem_rdata_q;

  logic [AW-1:0]   sx_w, sy_w;
  logic [AW-1:0]   elem_addr [NEL];
  logic [AW-1:0]   lane_addr [LANES];
  logic [BITS-1:0] lane_data [LANES];
  logic [LANES-1:0] lane_en;
  logic            store_en;

  assign sx_w = AW'(sx_q);
  assign sy_w = AW'(sy_q);

  // Row/column of each element are constants, so each address is a base plus two constant multiples.
  for (genvar gk = 0; gk < NEL; gk++) begin : g_addr
    assign elem_addr[gk] = base_q + AW'(gk / SZ) * sy_w + AW'(gk % SZ) * sx_w;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_addr[l] = '0;
      lane_data[l] = '0;
    end
    lane_en = '0;
    for (int k = 0; k < NEL; k++) begin
      if (BW'(k / LANES) == beat_q) begin
        lane_addr[k % LANES] = elem_addr[k];
        lane_data[k % LANES] = rf_q[reg_q][k];
        lane_en[k % LANES]   = 1'b1;
      end
    end
  end

  assign store_en = (state_q == S_RUN) && !is_load_q;

  // Later assignments win: engine lanes override the host, higher lanes override lower ones.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (store_en) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_en[l]) mem[lane_addr[l]] <= lane_data[l];
      end
    end
    for (int l = 0; l < LANES; l++) rd_data_q[l] <= mem[lane_addr[l]];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mem_rdata_q <= '0;
    else         mem_rdata_q <= mem[mem_raddr];
  end

  always_comb begin
    state_d    = state_q;
    is_load_d  = is_load_q;
    reg_d      = reg_q;
    base_d     = base_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    beat_d     = beat_q;
    wb_valid_d = 1'b0;
    wb_beat_d  = wb_beat_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_func)
            3'b001, 3'b010: begin
              state_d   = S_RUN;
              is_load_d = (cmd_func == 3'b001);
              reg_d     = cmd_reg;
              base_d    = cmd_addr;
              sx_d      = cmd_stride_x;
              sy_d      = cmd_stride_y;
              beat_d    = '0;
            end
            3'b011: begin
              state_d = S_CLR;
              reg_d   = cmd_reg;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Load data returns one cycle after issue, so the writeback trails the beat by one.
        wb_valid_d = is_load_q;
        wb_beat_d  = beat_q;
        if (beat_q == BW'(NB - 1)) begin
          state_d = is_load_q ? S_WB : S_IDLE;
          done_d  = !is_load_q;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_CLR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rf_d = rf_q;
    if (state_q == S_CLR) begin
      for (int k = 0; k < NEL; k++) rf_d[reg_q][k] = '0;
    end
    if (wb_valid_q) begin
      for (int k = 0; k < NEL; k++) begin
        if (BW'(k / LANES) == wb_beat_q) rf_d[reg_q][k] = rd_data_q[k % LANES];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      is_load_q  <= 1'b0;
      reg_q      <= '0;
      base_q     <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      beat_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_beat_q  <= '0;
      done_q     <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        for (int k = 0; k < NEL; k++) rf_q[r][k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      reg_q      <= reg_d;
      base_q     <= base_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      beat_q     <= beat_d;
      wb_valid_q <= wb_valid_d;
      wb_beat_q  <= wb_beat_d;
      done_q     <= done_d;
      rf_q       <= rf_d;
    end
  end

  for (genvar gk = 0; gk < NEL; gk++) begin : g_view
    assign reg_view[gk*BITS +: BITS] = rf_q[view_reg][gk];
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign mem_rdata = mem_rdata_q;

endmodule
